// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter
//  Purpose  : Writeback initiator for the register file write port. Collects
//             results from the ALU and the load unit through valid/ready
//             handshakes. Load data is aligned and extended when it is
//             captured. Each source has its own FIFO. One registered write is
//             issued per cycle. The load FIFO has priority, but the ALU is
//             guaranteed at least one slot in three.
//  Ports    : r_clk, r_rst (async, active-low)
//             alu_valid/alu_ready/alu_rd/alu_data           ALU result input
//             ld_valid/ld_ready/ld_rd/ld_funct3/ld_addr_lo/ld_rdata
//                                                            load result input
//             wb_we/wb_addr_rd/wb_data_rd                   register file write
//             ld_err   one-cycle pulse after capturing an illegal funct3
//             busy     any FIFO non-empty or a write in flight
//  Revision : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int DWIDTH = 32,  // load extension assumes 32
    parameter int AWIDTH = 5,
    parameter int DEPTH  = 2    // power of 2, >= 2
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [AWIDTH-1:0] alu_rd,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [AWIDTH-1:0] ld_rd,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_addr_lo,
    input  logic [DWIDTH-1:0] ld_rdata,
    output logic              wb_we,
    output logic [AWIDTH-1:0] wb_addr_rd,
    output logic [DWIDTH-1:0] wb_data_rd,
    output logic              ld_err,
    output logic              busy
);
    localparam int EW = AWIDTH + DWIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);
    localparam logic [1:0]    C_STARVE  = 2'd2;
    localparam int            C_SRC_ALU = 0;
    localparam int            C_SRC_LD  = 1;

    // ------------------------------------------------------------------
    // Load alignment / extension (done before the FIFO)
    // ------------------------------------------------------------------
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [DWIDTH-1:0] w_ld_ext;
    logic              w_ld_illegal;

    always_comb begin
        w_ld_byte    = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        w_ld_half    = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        w_ld_ext     = ld_rdata;
        w_ld_illegal = 1'b0;
        case (ld_funct3)
            3'b000:  w_ld_ext = {{(DWIDTH-8){w_ld_byte[7]}}, w_ld_byte};
            3'b001:  w_ld_ext = {{(DWIDTH-16){w_ld_half[15]}}, w_ld_half};
            3'b010:  w_ld_ext = ld_rdata;
            3'b100:  w_ld_ext = {{(DWIDTH-8){1'b0}}, w_ld_byte};
            3'b101:  w_ld_ext = {{(DWIDTH-16){1'b0}}, w_ld_half};
            default: begin
                // Unknown encodings are written back as a full word.
                w_ld_ext     = ld_rdata;
                w_ld_illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-source FIFOs: index 0 = ALU, index 1 = load
    // ------------------------------------------------------------------
    logic [EW-1:0] w_fifo_in  [2];
    logic [EW-1:0] w_fifo_out [2];
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_full;
    logic [1:0]    w_empty;
    logic          w_alu_ready;
    logic          w_ld_ready;

    // Ready depends only on the registered count. It is also held low
    // while reset is asserted, because nothing can be captured then.
    assign w_alu_ready = r_rst & ~w_full[C_SRC_ALU];
    assign w_ld_ready  = r_rst & ~w_full[C_SRC_LD];
    assign alu_ready   = w_alu_ready;
    assign ld_ready    = w_ld_ready;

    assign w_push[C_SRC_ALU]    = alu_valid & w_alu_ready;
    assign w_push[C_SRC_LD]     = ld_valid & w_ld_ready;
    assign w_fifo_in[C_SRC_ALU] = {alu_rd, alu_data};
    assign w_fifo_in[C_SRC_LD]  = {ld_rd, w_ld_ext};

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [EW-1:0] mem_q [DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;

        // Pointers wrap naturally since DEPTH is a power of two.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (w_push[gi]) wr_ptr_d = wr_ptr_q + PW'(1);
            if (w_pop[gi])  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({w_push[gi], w_pop[gi]})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge r_clk or negedge r_rst) begin
            if (!r_rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage needs no reset; validity is tracked by count_q.
        always_ff @(posedge r_clk) begin
            if (w_push[gi]) mem_q[wr_ptr_q] <= w_fifo_in[gi];
        end

        assign w_fifo_out[gi] = mem_q[rd_ptr_q];
        assign w_full[gi]     = (count_q == C_FULL);
        assign w_empty[gi]    = (count_q == '0);
    end

    // ------------------------------------------------------------------
    // Arbitration: the load FIFO wins unless the ALU has waited twice
    // ------------------------------------------------------------------
    logic [1:0] starve_q, starve_d;
    logic       w_alu_grant;
    logic       w_ld_grant;

    assign w_alu_grant = ~w_empty[C_SRC_ALU] &
                         (w_empty[C_SRC_LD] | (starve_q == C_STARVE));
    assign w_ld_grant  = ~w_empty[C_SRC_LD] & ~w_alu_grant;
    assign w_pop[C_SRC_ALU] = w_alu_grant;
    assign w_pop[C_SRC_LD]  = w_ld_grant;

    // Resetting on a grant keeps the counter at or below C_STARVE.
    always_comb begin
        starve_d = starve_q;
        if (w_alu_grant)
            starve_d = '0;
        else if (!w_empty[C_SRC_ALU])
            starve_d = starve_q + 2'd1;
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic              wb_we_q,   wb_we_d;
    logic [AWIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [DWIDTH-1:0] wb_data_q, wb_data_d;
    logic              ld_err_q,  ld_err_d;
    logic [EW-1:0]     w_sel;

    always_comb begin
        w_sel     = w_ld_grant ? w_fifo_out[C_SRC_LD] : w_fifo_out[C_SRC_ALU];
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (w_alu_grant || w_ld_grant) begin
            // x0 entries are consumed but never written.
            wb_we_d   = (w_sel[EW-1 -: AWIDTH] != '0);
            wb_addr_d = w_sel[EW-1 -: AWIDTH];
            wb_data_d = w_sel[DWIDTH-1:0];
        end
        ld_err_d = w_push[C_SRC_LD] & w_ld_illegal;
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            starve_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            ld_err_q  <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            ld_err_q  <= ld_err_d;
        end
    end

    assign wb_we      = wb_we_q;
    assign wb_addr_rd = wb_addr_q;
    assign wb_data_rd = wb_data_q;
    assign ld_err     = ld_err_q;
    assign busy       = ~w_empty[C_SRC_ALU] | ~w_empty[C_SRC_LD] | wb_we_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter
//  Purpose  : Directed self-checking bench for wb_arbiter. It covers reset,
//             a single ALU write, load extension, contention with
//             backpressure, x0 discard, and reset in the middle of traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;
    localparam int DWIDTH = 32;
    localparam int AWIDTH = 5;
    localparam int DEPTH  = 2;

    logic              r_clk = 1'b0;
    logic              r_rst = 1'b0;
    logic              alu_valid = 1'b0;
    logic              alu_ready;
    logic [AWIDTH-1:0] alu_rd = '0;
    logic [DWIDTH-1:0] alu_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic [AWIDTH-1:0] ld_rd = '0;
    logic [2:0]        ld_funct3 = '0;
    logic [1:0]        ld_addr_lo = '0;
    logic [DWIDTH-1:0] ld_rdata = '0;
    logic              wb_we;
    logic [AWIDTH-1:0] wb_addr_rd;
    logic [DWIDTH-1:0] wb_data_rd;
    logic              ld_err;
    logic              busy;

    wb_arbiter #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .ld_rdata   (ld_rdata),
        .wb_we      (wb_we),
        .wb_addr_rd (wb_addr_rd),
        .wb_data_rd (wb_data_rd),
        .ld_err     (ld_err),
        .busy       (busy)
    );

    always #5 r_clk = ~r_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle.
    task automatic tick;
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] exp, input logic err);
        ld_valid   = 1'b1;
        ld_rd      = 5'd7;
        ld_funct3  = f3;
        ld_addr_lo = off;
        ld_rdata   = 32'h8070_F0FF;
        chk({tag, "_ready"}, ld_ready, 1);
        tick;
        ld_valid = 1'b0;
        ld_rdata = 32'h0;
        chk({tag, "_err1"}, ld_err, err);
        chk({tag, "_we0"}, wb_we, 0);
        tick;
        chk({tag, "_we"}, wb_we, 1);
        chk({tag, "_addr"}, wb_addr_rd, 7);
        chk({tag, "_data"}, wb_data_rd, exp);
        chk({tag, "_err2"}, ld_err, 0);
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Contention expectations, indexed by cycle 1..12 and by write order
    logic [12:1] exp_ldr = 12'b1011_0110_1111;
    logic [12:1] exp_alr = 12'b0100_1001_0011;
    int          exp_seq[14] = '{8, 9, 20, 10, 11, 21, 12, 13, 22, 14, 15, 23, 16, 24};

    initial begin
        int          li;
        int          ai;
        logic        l_acc;
        logic        a_acc;
        logic [31:0] exp_data;

        // ---------------- reset with random inputs ----------------
        r_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            alu_valid  = 1'($urandom);
            alu_rd     = 5'($urandom);
            alu_data   = $urandom;
            ld_valid   = 1'($urandom);
            ld_rd      = 5'($urandom);
            ld_funct3  = 3'($urandom);
            ld_addr_lo = 2'($urandom);
            ld_rdata   = $urandom;
            tick;
        end
        chk("rst_we", wb_we, 0);
        chk("rst_addr", wb_addr_rd, 0);
        chk("rst_data", wb_data_rd, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_busy", busy, 0);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        r_rst     = 1'b1;
        #1;
        chk("rel_alu_ready", alu_ready, 1);
        chk("rel_ld_ready", ld_ready, 1);
        tick;

        // ---------------- single ALU write ----------------
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        tick;
        alu_valid = 1'b0;
        chk("alu_we_e0", wb_we, 0);
        chk("alu_busy", busy, 1);
        tick;
        chk("alu_we", wb_we, 1);
        chk("alu_addr", wb_addr_rd, 5);
        chk("alu_data", wb_data_rd, 32'hDEAD_BEEF);
        tick;
        chk("alu_we_off", wb_we, 0);
        chk("alu_addr_hold", wb_addr_rd, 5);
        chk("alu_data_hold", wb_data_rd, 32'hDEAD_BEEF);
        chk("alu_idle", busy, 0);

        // ---------------- load extension ----------------
        do_load("lb1",  3'b000, 2'd1, 32'hFFFF_FFF0, 1'b0);
        do_load("lbu3", 3'b100, 2'd3, 32'h0000_0080, 1'b0);
        do_load("lh2",  3'b001, 2'd2, 32'hFFFF_8070, 1'b0);
        do_load("lhu0", 3'b101, 2'd0, 32'h0000_F0FF, 1'b0);
        do_load("lh3",  3'b001, 2'd3, 32'hFFFF_8070, 1'b0);
        do_load("lw1",  3'b010, 2'd1, 32'h8070_F0FF, 1'b0);
        do_load("f011", 3'b011, 2'd1, 32'h8070_F0FF, 1'b1);
        do_load("f111", 3'b111, 2'd0, 32'h8070_F0FF, 1'b1);

        // ---------------- contention + backpressure ----------------
        li = 0;
        ai = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            if (cyc <= 12) begin
                ld_valid   = 1'b1;
                ld_rd      = 5'(8 + li);
                ld_funct3  = 3'b010;
                ld_addr_lo = 2'(li);
                ld_rdata   = 32'hB000_0000 + 32'(li);
                alu_valid  = 1'b1;
                alu_rd     = 5'(20 + ai);
                alu_data   = 32'hA000_0000 + 32'(ai);
                chk($sformatf("cont_ld_ready_c%0d", cyc), ld_ready, exp_ldr[cyc]);
                chk($sformatf("cont_alu_ready_c%0d", cyc), alu_ready, exp_alr[cyc]);
            end else begin
                ld_valid  = 1'b0;
                alu_valid = 1'b0;
            end
            l_acc = ld_valid & ld_ready;
            a_acc = alu_valid & alu_ready;
            tick;
            if (l_acc) li++;
            if (a_acc) ai++;
            if (cyc >= 2) begin
                if (exp_seq[cyc-2] >= 20)
                    exp_data = 32'hA000_0000 + 32'(exp_seq[cyc-2] - 20);
                else
                    exp_data = 32'hB000_0000 + 32'(exp_seq[cyc-2] - 8);
                chk($sformatf("cont_we_c%0d", cyc), wb_we, 1);
                chk($sformatf("cont_addr_c%0d", cyc), wb_addr_rd, exp_seq[cyc-2]);
                chk($sformatf("cont_data_c%0d", cyc), wb_data_rd, exp_data);
            end
        end
        chk("cont_ld_accepted", li, 9);
        chk("cont_alu_accepted", ai, 5);
        tick;
        chk("cont_drain_we", wb_we, 0);
        chk("cont_drain_busy", busy, 0);

        // ---------------- x0 discard ----------------
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'h0000_1111;
        tick;
        alu_rd    = 5'd1;
        alu_data  = 32'h0000_2222;
        tick;
        alu_valid = 1'b0;
        chk("x0_we", wb_we, 0);
        chk("x0_busy", busy, 1);
        tick;
        chk("x1_we", wb_we, 1);
        chk("x1_addr", wb_addr_rd, 1);
        chk("x1_data", wb_data_rd, 32'h0000_2222);
        tick;
        chk("x1_we_off", wb_we, 0);

        // ---------------- reset in the middle of traffic ----------------
        alu_valid  = 1'b1;
        alu_rd     = 5'd3;
        alu_data   = 32'h3333_3333;
        ld_valid   = 1'b1;
        ld_rd      = 5'd4;
        ld_funct3  = 3'b010;
        ld_rdata   = 32'h4444_4444;
        tick;
        tick;
        chk("mid_pre_we", wb_we, 1);
        r_rst = 1'b0;
        #1;
        chk("mid_rst_we", wb_we, 0);
        chk("mid_rst_busy", busy, 0);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        tick;
        r_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk($sformatf("mid_post_we_%0d", i), wb_we, 0);
            chk($sformatf("mid_post_busy_%0d", i), busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback initiator for the 2-read/1-write register file: owns its single write port (r_we, r_addr_rd, r_data_rd).
- Accepts completed results from two producers, the ALU and the load unit, each over a valid/ready handshake.
- Aligns and sign/zero-extends load data.
- Buffers each source in a small FIFO and arbitrates one registered write per cycle.

Parameters:
DWIDTH, 32, data width; load extension logic is defined for 32 only.
AWIDTH, 5, register address width.
DEPTH, 2, entries per source FIFO; power of 2, minimum 2.

Ports:
r_clk  in  1  clock
r_rst  in  1  reset; asynchronous, active-low
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU FIFO not full
alu_rd  in  AWIDTH  ALU destination register
alu_data  in  DWIDTH  ALU result
ld_valid  in  1  load result offered
ld_ready  out  1  load FIFO not full
ld_rd  in  AWIDTH  load destination register
ld_funct3  in  3  load type (RISC-V encoding)
ld_addr_lo  in  2  byte offset of the load address
ld_rdata  in  DWIDTH  raw aligned memory word
wb_we  out  1  register file write enable
wb_addr_rd  out  AWIDTH  register file write address
wb_data_rd  out  DWIDTH  register file write data
ld_err  out  1  one-cycle pulse on illegal funct3
busy  out  1  any FIFO non-empty or wb_we high

Behaviour:
- Reset (async, r_rst=0): both FIFOs empty, pointers/counts 0, starve counter 0.
  - Outputs on reset: wb_we=0, wb_addr_rd=0, wb_data_rd=0, ld_err=0, busy=0; alu_ready=1 and ld_ready=1 once reset is released.
- Reset mid-operation discards all buffered results; no write is issued for them.
- Handshake:
  - Transfer occurs when valid&&ready at a rising edge.
  - ready depends only on the registered FIFO count (no combinational path from valid).
  - Data and address must be held stable while valid=1 and ready=0.
- Load extension, applied at capture so the FIFO stores final data:
  - 000 LB: byte ld_addr_lo, sign-extended.
  - 001 LH: half ld_addr_lo[1], sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte, zero-extended.
  - 101 LHU: half, zero-extended.
  - 011/110/111: treated as LW; ld_err=1 for the cycle after capture.
  - ld_addr_lo[0] is ignored for halves and ld_addr_lo is ignored for LW (misalignment is handled upstream).
- Arbitration, once per cycle, pops at most one entry:
  - The load FIFO has priority.
  - The starve counter increments when the ALU FIFO is non-empty and not granted.
  - When starve==2, the ALU wins, and the counter clears on any ALU grant.
  - Net effect: the ALU receives at least 1 of every 3 slots under contention.
- Output register:
  - On a grant, at the next edge: wb_we=(rd!=0), wb_addr_rd=rd, wb_data_rd=data.
  - With no grant: wb_we=0, while wb_addr_rd and wb_data_rd hold their last values.
  - rd==0 entries are popped and consumed but produce wb_we=0; the register file never sees an x0 write.
- Latency: a result accepted at edge E0 appears with wb_we=1 after edge E1 (2-cycle path, no bypass), provided it wins arbitration at E1.
- Throughput: 1 write per cycle sustained.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, but ready was 0 that cycle, so no push occurs. Push and pop in the same cycle on a non-full FIFO keeps the count unchanged.
- FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Write ordering: in-order within each source; no ordering guarantee across sources (the hazard unit upstream guarantees no same-rd overlap).

Test Plan:
- Reset: hold r_rst=0 with random inputs -> all outputs 0, busy=0; release -> alu_ready=ld_ready=1.
- Single ALU: alu rd=5 data=0xDEADBEEF -> wb_we=1, addr=5, data=0xDEADBEEF exactly 2 cycles after acceptance, for one cycle.
- Load extension: rdata=0x8070F0FF.
  - LB off=1 -> 0xFFFFFFF0.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF8070.
  - LHU off=0 -> 0x0000F0FF.
  - funct3=011 -> 0x8070F0FF with ld_err pulse.
- Contention and backpressure: both sources valid every cycle for 12 cycles.
  - Write pattern is L,L,A repeating.
  - ld_ready/alu_ready drop to 0 when the respective count reaches DEPTH.
  - No lost or duplicated entries, per-source order preserved.
- x0 discard: ALU rd=0 then rd=1 back-to-back -> the rd=0 slot shows wb_we=0; rd=1 writes on the following cycle.
- Mid-operation reset: fill both FIFOs, assert r_rst for 1 cycle -> wb_we=0 immediately; after release, no stale writes and busy=0.
